inst_refill_axi: RTL and testbench

Parametrised instruction-side AXI read master that replaces the fire-and-forget fetch front-end with a full-handshake refill engine. Accepts one fetch request at a time from the I-cache/PC stage and issues either a LINE_WORDS-beat incrementing burst (cached) or a single-beat read (uncached). Assembles the line in an internal buffer and returns the whole line plus the critical word. Correctly drains bursts cancelled by a pipeline flush.

---
 rtl/inst_refill_axi_pkg.sv | 26 ++
 rtl/inst_refill_axi_if.sv | 37 +++
 rtl/inst_refill_axi_line_buf.sv | 44 ++++
 rtl/inst_refill_axi.sv | 142 ++++++++++++++
 tb/tb_inst_refill_axi.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_refill_axi_pkg.sv
// Shared constants, state encoding and address helpers for the
// instruction-side AXI refill engine.
package inst_refill_axi_pkg;

   // Default AXI ID used for instruction fetches.
   localparam logic [3:0]  AXI_INST_ID     = 4'h0;

   // AXI encodings: 4-byte beats, incrementing bursts.
   localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;

   // kseg0/kseg1 virtual addresses map onto physical by dropping the top 3 bits.
   localparam logic [31:0] KSEG_PADDR_MASK = 32'h1FFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN
   } state_t;

   function automatic logic [31:0] kseg_to_paddr(input logic [31:0] vaddr);
      return vaddr & KSEG_PADDR_MASK;
   endfunction

endpackage

// File: rtl/inst_refill_axi_if.sv
// AXI read-address and read-data channels between the refill engine
// (master) and the interconnect (slave).
interface inst_refill_axi_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/inst_refill_axi_line_buf.sv
// Line assembly buffer: LINE_WORDS x 32 registers with indexed write,
// whole-buffer clear, flattened line output and critical-word mux.
module refill_line_buf #(
   parameter int LINE_WORDS = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          clear,
   input  logic                          we,
   input  logic [$clog2(LINE_WORDS)-1:0] widx,
   input  logic [31:0]                   wdata,
   input  logic [$clog2(LINE_WORDS)-1:0] ridx,
   output logic [32*LINE_WORDS-1:0]      line,
   output logic [31:0]                   word
);

   logic [31:0] mem [LINE_WORDS];

   // Buffer storage: cleared at request acceptance, written one beat at a time.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: the array is built from flops, not a RAM macro, so it can take an
      // async reset; that keeps resp_line at zero out of reset.
      if (!resetn) begin
         for (int i = 0; i < LINE_WORDS; i++) mem[i] <= '0;
      end else if (clear) begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless
         // of block evaluation order.
         for (int i = 0; i < LINE_WORDS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Flatten the buffer, word 0 in the least significant bits.
   always_comb begin
      // NOTE: default first so no path through the block leaves line unassigned
      // (which would infer a latch).
      line = '0;
      for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] = mem[i];
   end

   assign word = mem[ridx];

endmodule

// File: rtl/inst_refill_axi.sv
// Instruction refill engine: accepts one fetch at a time, issues a line
// burst (cached) or a single-beat read (uncached), assembles the line and
// returns it with the critical word. Flushed bursts are drained silently.
module inst_refill_axi
   import inst_refill_axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID     = AXI_INST_ID,
   parameter int         LINE_WORDS = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   input  logic                     req_uncached,
   output logic                     resp_valid,
   output logic                     resp_err,
   output logic                     resp_uncached,
   output logic [31:0]              resp_addr,
   output logic [31:0]              resp_word,
   output logic [32*LINE_WORDS-1:0] resp_line,
   inst_refill_axi_if.master        axi
);

   localparam int          OFFS_W    = $clog2(LINE_WORDS);
   localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS*4 - 1);
   localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);
   localparam logic [OFFS_W-1:0] CNT_MAX = OFFS_W'(LINE_WORDS - 1);

   state_t              state_q, state_d;
   logic [31:0]         addr_q;
   logic [3:0]          arlen_q;
   logic                uncached_q;
   logic [OFFS_W-1:0]   offs_q;
   logic [OFFS_W-1:0]   cnt_q;
   logic                err_q;
   logic                flush_seen_q;
   logic                resp_q;
   logic                resp_err_q;

   logic                accept;
   logic                beat;
   logic [31:0]         paddr;
   logic [32*LINE_WORDS-1:0] buf_line;

   assign paddr  = kseg_to_paddr(req_addr);
   assign accept = req_valid & req_ready;
   assign beat   = axi.rvalid & axi.rready & (axi.rid == AXI_ID);

   // Constant AR attributes.
   assign axi.arid    = AXI_ID;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0000;
   assign axi.arprot  = 3'b000;

   // Address/length come straight from registers, so they are stable while arvalid waits.
   assign axi.araddr  = addr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arvalid = (state_q == ST_ADDR);
   assign axi.rready  = (state_q == ST_DATA) | (state_q == ST_DRAIN);

   // Held low during reset, then open whenever idle and not flushing.
   assign req_ready  = resetn & (state_q == ST_IDLE) & ~flush;

   assign resp_valid    = resp_q & ~flush;
   assign resp_err      = resp_valid & resp_err_q;
   assign resp_uncached = uncached_q;
   assign resp_addr     = addr_q;
   assign resp_line     = uncached_q ? '0 : buf_line;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; a flush seen anywhere in ADDR diverts the burst to DRAIN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ADDR;
         ST_ADDR:  if (axi.arready) state_d = (flush | flush_seen_q) ? ST_DRAIN : ST_DATA;
         ST_DATA: begin
            if (beat && axi.rlast) state_d = ST_IDLE;
            else if (flush)        state_d = ST_DRAIN;
         end
         ST_DRAIN: if (beat && axi.rlast) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request latch, beat counting, error accumulation and response pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q       <= '0;
         arlen_q      <= '0;
         uncached_q   <= 1'b0;
         offs_q       <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         flush_seen_q <= 1'b0;
         resp_q       <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_q <= 1'b0;
         if (accept) begin
            addr_q       <= req_uncached ? paddr : (paddr & LINE_MASK);
            arlen_q      <= req_uncached ? 4'd0 : LINE_LEN;
            uncached_q   <= req_uncached;
            offs_q       <= req_addr[OFFS_W+1:2];
            cnt_q        <= '0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
         end
         if (state_q == ST_ADDR && flush) flush_seen_q <= 1'b1;
         if (state_q == ST_DATA && beat) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            err_q <= err_q | (axi.rresp != 2'b00);
            if (axi.rlast) begin
               resp_q     <= ~flush;
               resp_err_q <= err_q | (axi.rresp != 2'b00) | (32'(cnt_q) != 32'(arlen_q));
            end
         end
      end
   end

   refill_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
      .clk    (clk),
      .resetn (resetn),
      .clear  (accept),
      .we     ((state_q == ST_DATA) & beat),
      .widx   (cnt_q),
      .wdata  (axi.rdata),
      .ridx   (uncached_q ? '0 : offs_q),
      .line   (buf_line),
      .word   (resp_word)
   );

endmodule

// File: tb/tb_inst_refill_axi.sv
// Randomized bench for inst_refill_axi: a transaction-level model of the
// refill rules predicts AR requests and responses; a negedge monitor
// compares resp_valid every cycle and the response fields when due.
module tb_inst_refill_axi;

   localparam int LW = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_uncached = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_ready, resp_valid, resp_err, resp_uncached;
   logic [31:0] resp_addr, resp_word;
   logic [32*LW-1:0] resp_line;

   inst_refill_axi_if axi();

   inst_refill_axi #(.AXI_ID(4'h0), .LINE_WORDS(LW)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_uncached  (req_uncached),
      .resp_valid    (resp_valid),
      .resp_err      (resp_err),
      .resp_uncached (resp_uncached),
      .resp_addr     (resp_addr),
      .resp_word     (resp_word),
      .resp_line     (resp_line),
      .axi           (axi.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0]      addr;
      logic [31:0]      word;
      logic [32*LW-1:0] line;
      logic             err;
      logic             unc;
   } resp_t;

   resp_t       exp_r;
   bit          resp_due = 1'b0;
   bit          mon_en = 1'b0;
   logic [31:0] last_word;
   logic [255:0] last_line;
   logic        last_err, last_unc;
   logic [31:0] seen_araddr;
   logic [3:0]  seen_arlen;

   // Every cycle: resp_valid must match the model; when due, all fields too.
   always @(negedge clk) begin
      if (mon_en) begin
         check("resp_valid", resp_valid, resp_due);
         if (resp_valid && resp_due) begin
            check("resp_addr", resp_addr, exp_r.addr);
            check("resp_word", resp_word, exp_r.word);
            check("resp_line", resp_line, exp_r.line);
            check("resp_err", resp_err, exp_r.err);
            check("resp_uncached", resp_uncached, exp_r.unc);
            last_word = resp_word;
            last_line = resp_line;
            last_err  = resp_err;
            last_unc  = resp_uncached;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // One fetch. fmode: 0 none, 1 flush in ADDR, 2 flush in DATA, 3 flush in pulse cycle.
   // base != 0 makes the transaction directed (fixed data, fixed flush points).
   task automatic txn(input logic [31:0] va, input bit unc, input int fmode, input int err_beat,
                      input bit early, input int ar_wait, input bit foreign, input logic [31:0] base);
      logic [31:0] pa, exp_ar, d;
      logic [3:0]  exp_len;
      logic [31:0] words [LW];
      logic [1:0]  rr;
      int          nbeats, fk, tries, last_idx, offs;
      bit          err, dropped;
      pa      = va & 32'h1FFF_FFFF;
      exp_ar  = unc ? pa : {pa[31:5], 5'b0};
      exp_len = unc ? 4'd0 : 4'(LW - 1);
      nbeats  = unc ? 1 : (early ? 6 : LW);
      offs    = int'(va[4:2]);
      for (int i = 0; i < LW; i++) words[i] = '0;

      // Request phase, sometimes blocked by a simultaneous flush.
      req_valid = 1'b1; req_addr = va; req_uncached = unc;
      if (base == 0 && $urandom_range(0, 3) == 0) begin
         flush = 1'b1;
         samp();
         check("flush_blocks_req", req_ready, 1'b0);
         tick();
         flush = 1'b0;
         samp();
         check("no_accept_on_flush", axi.arvalid, 1'b0);
      end else begin
         samp();
      end
      tries = 0;
      while (!req_ready && tries < 20) begin
         tick(); samp(); tries++;
      end
      check("req_ready_idle", req_ready, 1'b1);
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_uncached = 1'($urandom);

      // Address phase with optional backpressure.
      fk = (fmode == 1) ? ((base != 0) ? 1 : $urandom_range(0, ar_wait)) : -1;
      for (int c = 0; c <= ar_wait; c++) begin
         axi.arready = (c == ar_wait);
         flush = (c == fk);
         samp();
         check("arvalid", axi.arvalid, 1'b1);
         check("araddr", axi.araddr, exp_ar);
         check("arlen", axi.arlen, exp_len);
         if (c == 0) begin
            check("ar_const", {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                  {4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
            seen_araddr = axi.araddr;
            seen_arlen  = axi.arlen;
         end
         tick();
      end
      axi.arready = 1'b0; flush = 1'b0;

      // Data phase: gaps, foreign beats, optional flush, then the matching beat.
      dropped = (fmode == 1);
      err = 1'b0;
      fk = (fmode == 2) ? ((base != 0) ? 3 : $urandom_range(0, nbeats - 1)) : -1;
      for (int b = 0; b < nbeats; b++) begin
         int gaps;
         gaps = foreign ? $urandom_range(1, 2) : $urandom_range(0, 2);
         if (b == fk && gaps == 0) gaps = 1;
         for (int g = 0; g < gaps; g++) begin
            axi.rvalid = foreign ? 1'($urandom) : 1'b0;
            axi.rid    = 4'h1;
            axi.rdata  = $urandom;
            axi.rresp  = 2'($urandom);
            axi.rlast  = 1'($urandom);
            flush      = (b == fk) && (g == gaps - 1);
            samp();
            check("rready_gap", axi.rready, 1'b1);
            tick();
         end
         flush = 1'b0;
         if (b == fk) dropped = 1'b1;
         d  = (base != 0) ? (unc ? base : base + 32'(b)) : $urandom;
         rr = (b == err_beat) ? 2'b10 : 2'b00;
         axi.rvalid = 1'b1; axi.rid = 4'h0; axi.rdata = d; axi.rresp = rr;
         axi.rlast  = (b == nbeats - 1);
         samp();
         check("rready_beat", axi.rready, 1'b1);
         tick();
         words[(b < LW) ? b : LW - 1] = d;
         err |= (rr != 2'b00);
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0;

      // Response cycle prediction.
      last_idx = (nbeats - 1 < LW - 1) ? nbeats - 1 : LW - 1;
      exp_r.addr = exp_ar;
      exp_r.unc  = unc;
      exp_r.err  = err | (last_idx != int'(exp_len));
      exp_r.word = unc ? words[0] : words[offs];
      exp_r.line = '0;
      if (!unc) for (int i = 0; i < LW; i++) exp_r.line[32*i +: 32] = words[i];
      resp_due = !dropped && (fmode != 3);
      flush    = (fmode == 3);
      samp();
      check("req_ready_after_last", req_ready, !flush);
      tick();
      resp_due = 1'b0; flush = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0;
      axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
      #2 resetn = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_arvalid", axi.arvalid, 1'b0);
      check("rst_rready", axi.rready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_araddr", axi.araddr, 32'h0);
      check("rst_arlen", axi.arlen, 4'h0);
      check("rst_line", resp_line, '0);
      #20 resetn = 1'b1;
      samp();
      check("req_ready_after_rst", req_ready, 1'b1);
      mon_en = 1'b1;
      tick();

      // Directed: cached line fill, critical word at offset 5.
      txn(32'h9FC0_0014, 1'b0, 0, -1, 1'b0, 0, 1'b0, 32'h100);
      check("lit_araddr", seen_araddr, 32'h1FC0_0000);
      check("lit_arlen", seen_arlen, 4'd7);
      check("lit_word", last_word, 32'h105);
      check("lit_line_top", last_line[255:224], 32'h107);
      check("lit_err", last_err, 1'b0);

      // Directed: uncached single beat.
      txn(32'hBFC0_0004, 1'b1, 0, -1, 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
      check("lit_unc_araddr", seen_araddr, 32'h1FC0_0004);
      check("lit_unc_arlen", seen_arlen, 4'd0);
      check("lit_unc_word", last_word, 32'hDEAD_BEEF);
      check("lit_unc_line", last_line, '0);
      check("lit_unc_flag", last_unc, 1'b1);

      // Directed: AR backpressure with flush, flush mid-burst, flush on the pulse.
      txn(32'h8000_1000, 1'b0, 1, -1, 1'b0, 3, 1'b0, 32'h200);
      txn(32'h8000_2008, 1'b0, 2, -1, 1'b0, 0, 1'b0, 32'h300);
      txn(32'h8000_3000, 1'b0, 3, -1, 1'b0, 1, 1'b0, 32'h350);

      // Directed: rresp error, foreign IDs, early rlast.
      txn(32'h8000_4010, 1'b0, 0, 3, 1'b0, 0, 1'b0, 32'h400);
      check("lit_rresp_err", last_err, 1'b1);
      txn(32'h8000_501C, 1'b0, 0, -1, 1'b0, 2, 1'b1, 32'h500);
      check("lit_foreign_word", last_word, 32'h507);
      check("lit_foreign_err", last_err, 1'b0);
      txn(32'h8000_6004, 1'b0, 0, -1, 1'b1, 0, 1'b0, 32'h600);
      check("lit_early_err", last_err, 1'b1);
      check("lit_early_word", last_word, 32'h601);

      // Randomized fetches.
      for (int n = 0; n < 40; n++) begin
         bit u;
         int fm;
         u  = ($urandom_range(0, 3) == 0);
         fm = $urandom_range(0, 5);
         if (fm > 3) fm = 0;
         txn($urandom & 32'hFFFF_FFFC, u, fm,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, LW - 1) : -1,
             !u && ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
             1'($urandom), 32'h0);
      end

      // Async reset in the middle of a burst.
      req_valid = 1'b1; req_addr = 32'h8000_7000; req_uncached = 1'b0;
      samp();
      tick();
      req_valid = 1'b0; axi.arready = 1'b1;
      samp();
      tick();
      axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = 4'h0; axi.rdata = 32'h777; axi.rlast = 1'b0;
      samp();
      tick();
      #2 resetn = 1'b0;
      #1;
      axi.rvalid = 1'b0;
      check("mid_rst_rready", axi.rready, 1'b0);
      check("mid_rst_arvalid", axi.arvalid, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b0);
      check("mid_rst_resp_valid", resp_valid, 1'b0);
      check("mid_rst_araddr", axi.araddr, 32'h0);
      check("mid_rst_word", resp_word, 32'h0);
      check("mid_rst_line", resp_line, '0);
      @(posedge clk);
      #3 resetn = 1'b1;
      samp();
      check("post_rst_req_ready", req_ready, 1'b1);
      check("post_rst_arvalid", axi.arvalid, 1'b0);
      tick();
      txn(32'h9FC0_0008, 1'b0, 0, -1, 1'b0, 1, 1'b0, 32'h800);
      check("post_rst_word", last_word, 32'h802);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
